// File: rtl/alpha_serial_config_receiver_pkg.sv
// Shared ALPHA serial-config definitions: frame layout, counter widths, dreset qualification, FSM encoding.
// Used by both the transmitter and the receiver so that the two ends agree on the frame format.
package alpha_serial_config_receiver_pkg;

  localparam int unsigned ADDR_WIDTH         = 4;
  localparam int unsigned DATA_WIDTH         = 12;
  localparam int unsigned FRAME_BITS         = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_WIDTH          = $clog2(FRAME_BITS + 2);
  localparam int unsigned DRESET_MIN_DEFAULT = 8;

  // Frame is shifted MSB first: addr MSB arrives first, data LSB arrives last.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SHIFT       = 2'd1,
    ST_DRESET_PEND = 2'd2,
    ST_DRESET_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/alpha_serial_config_receiver_if.sv
// Pin and status bundle of the ALPHA serial configuration port.
// master = the side driving sin/sclk/pclk; slave = the receiver.
interface alpha_serial_config_receiver_if;
  import alpha_serial_config_receiver_pkg::*;

  logic                  sin;
  logic                  sclk;
  logic                  pclk;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_strobe;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  frame_error;
  logic                  dreset_detected;
  logic [CNT_WIDTH-1:0]  bit_count;

  modport master (
    output sin, sclk, pclk, read_addr,
    input  read_data, write_strobe, write_addr, write_data, frame_error, dreset_detected, bit_count
  );

  modport slave (
    input  sin, sclk, pclk, read_addr,
    output read_data, write_strobe, write_addr, write_data, frame_error, dreset_detected, bit_count
  );

endinterface

// File: rtl/alpha_pin_sync_edge.sv
// STAGES-deep synchroniser for one asynchronous pin, plus one extra flop for rising-edge detection.
// STAGES must be at least 2.
module alpha_pin_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = level & ~last_q;

endmodule

// File: rtl/alpha_serial_config_receiver.sv
// ALPHA serial configuration receiver: shifts frames on sclk, latches them into a register file on pclk,
// and treats sclk&pclk held high for a qualified duration as a register-file clear (dreset).
module alpha_serial_config_receiver
  import alpha_serial_config_receiver_pkg::*;
#(
  parameter int unsigned NUM_REGS          = 16,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DRESET_MIN_CYCLES = DRESET_MIN_DEFAULT
) (
  input logic                          clock,
  input logic                          reset,
  alpha_serial_config_receiver_if.slave bus
);

  localparam int unsigned           HOLD_WIDTH = $clog2(DRESET_MIN_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL   = CNT_WIDTH'(FRAME_BITS);
  localparam logic [CNT_WIDTH-1:0]  CNT_OVER   = CNT_WIDTH'(FRAME_BITS + 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_DONE  = HOLD_WIDTH'(DRESET_MIN_CYCLES);

  logic                  sin_lvl, sclk_lvl, pclk_lvl;
  logic                  sclk_rise_c, pclk_rise_c, sin_rise_unused;
  state_t                state_q, state_n, resume_q, resume_n;
  logic [HOLD_WIDTH-1:0] hold_q, hold_n;
  logic                  do_shift_c, do_latch_c, do_clear_c, both_high_c;
  logic [FRAME_BITS-1:0] shift_q;
  frame_t                frame_c;
  logic                  frame_ok_c;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // sin uses the same depth as sclk so the sampled bit lines up with the detected sclk edge.
  alpha_pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sin_sync (
    .clock(clock), .reset(reset), .pin(bus.sin), .level(sin_lvl), .rise_c(sin_rise_unused));
  alpha_pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clock(clock), .reset(reset), .pin(bus.sclk), .level(sclk_lvl), .rise_c(sclk_rise_c));
  alpha_pin_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk_sync (
    .clock(clock), .reset(reset), .pin(bus.pclk), .level(pclk_lvl), .rise_c(pclk_rise_c));

  assign frame_c     = frame_t'(shift_q);
  assign frame_ok_c  = (bus.bit_count == CNT_FULL) && (32'(frame_c.addr) < NUM_REGS);
  assign both_high_c = sclk_lvl & pclk_lvl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      hold_q   <= '0;
    end else begin
      state_q  <= state_n;
      resume_q <= resume_n;
      hold_q   <= hold_n;
    end
  end

  // Both lines high pre-empts any edge, so a same-cycle sclk/pclk rise neither shifts nor latches.
  always_comb begin
    state_n    = state_q;
    resume_n   = resume_q;
    hold_n     = hold_q;
    do_shift_c = 1'b0;
    do_latch_c = 1'b0;
    do_clear_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (both_high_c) begin
          state_n  = ST_DRESET_PEND;
          resume_n = state_q;
          hold_n   = HOLD_WIDTH'(1);
        end else if (sclk_rise_c) begin
          do_shift_c = 1'b1;
          state_n    = ST_SHIFT;
        end else if (pclk_rise_c) begin
          do_latch_c = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      ST_DRESET_PEND: begin
        if (!both_high_c) begin
          state_n = resume_q;
        end else if (hold_q >= HOLD_DONE) begin
          state_n    = ST_DRESET_HOLD;
          do_clear_c = 1'b1;
        end else begin
          hold_n = hold_q + HOLD_WIDTH'(1);
        end
      end
      ST_DRESET_HOLD: begin
        if (!sclk_lvl && !pclk_lvl) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q             <= '0;
      bus.bit_count       <= '0;
      bus.read_data       <= '0;
      bus.write_strobe    <= 1'b0;
      bus.write_addr      <= '0;
      bus.write_data      <= '0;
      bus.frame_error     <= 1'b0;
      bus.dreset_detected <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      bus.write_strobe    <= 1'b0;
      bus.frame_error     <= 1'b0;
      bus.dreset_detected <= 1'b0;
      bus.read_data       <= (32'(bus.read_addr) < NUM_REGS) ? regs_q[bus.read_addr] : '0;
      if (do_shift_c) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], sin_lvl};
        if (bus.bit_count != CNT_OVER) bus.bit_count <= bus.bit_count + CNT_WIDTH'(1);
      end
      if (do_latch_c) begin
        bus.bit_count <= '0;
        if (frame_ok_c) begin
          regs_q[frame_c.addr] <= frame_c.data;
          bus.write_strobe     <= 1'b1;
          bus.write_addr       <= frame_c.addr;
          bus.write_data       <= frame_c.data;
        end else begin
          bus.frame_error <= 1'b1;
        end
      end
      if (do_clear_c) begin
        shift_q             <= '0;
        bus.bit_count       <= '0;
        bus.dreset_detected <= 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alpha_serial_config_receiver.sv
// Randomized self-checking bench for alpha_serial_config_receiver against a queue-based frame model.
module tb_alpha_serial_config_receiver;
  import alpha_serial_config_receiver_pkg::*;

  localparam int unsigned NREGS = 12;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned DMIN  = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alpha_serial_config_receiver_if bus();

  alpha_serial_config_receiver #(
    .NUM_REGS(NREGS), .SYNC_STAGES(SYNC), .DRESET_MIN_CYCLES(DMIN)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bits shifted since last pclk/dreset, register contents, expected pulse counts.
  bit                    mq[$];
  logic [DATA_WIDTH-1:0] mregs [NREGS];
  int                    exp_strobes = 0, exp_errors = 0, exp_dresets = 0;
  logic [ADDR_WIDTH-1:0] exp_waddr = '0;
  logic [DATA_WIDTH-1:0] exp_wdata = '0;
  int                    seen_strobes = 0, seen_errors = 0, seen_dresets = 0;

  always @(negedge clock) begin
    if (bus.write_strobe)    seen_strobes++;
    if (bus.frame_error)     seen_errors++;
    if (bus.dreset_detected) seen_dresets++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_clear_regs();
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
  endtask

  task automatic model_latch();
    int unsigned a, d;
    a = 0;
    d = 0;
    if (mq.size() == FRAME_BITS) begin
      for (int i = 0; i < ADDR_WIDTH; i++) a = a * 2 + 32'(mq[i]);
      for (int i = ADDR_WIDTH; i < FRAME_BITS; i++) d = d * 2 + 32'(mq[i]);
      if (a < NREGS) begin
        mregs[a]  = DATA_WIDTH'(d);
        exp_waddr = ADDR_WIDTH'(a);
        exp_wdata = DATA_WIDTH'(d);
        exp_strobes++;
      end else begin
        exp_errors++;
      end
    end else begin
      exp_errors++;
    end
    mq.delete();
  endtask

  task automatic send_bit(input bit b);
    bus.sin = b;
    cycles(SYNC + 1);
    bus.sclk = 1'b1;
    cycles(4);
    bus.sclk = 1'b0;
    cycles(3);
    mq.push_back(b);
  endtask

  task automatic send_bits(input int unsigned first, input int unsigned last, input logic [FRAME_BITS-1:0] word);
    for (int unsigned i = first; i < last; i++)
      send_bit(i < FRAME_BITS ? word[FRAME_BITS-1-i] : 1'($urandom));
  endtask

  task automatic pulse_pclk();
    bus.pclk = 1'b1;
    cycles(4);
    bus.pclk = 1'b0;
    cycles(4);
    model_latch();
  endtask

  // Hold both lines high for n cycles, then release one line before the other.
  task automatic both_high(input int n, input bit pclk_first);
    bus.sclk = 1'b1;
    bus.pclk = 1'b1;
    cycles(n);
    if (pclk_first) bus.pclk = 1'b0;
    else            bus.sclk = 1'b0;
    cycles(4);
    bus.sclk = 1'b0;
    bus.pclk = 1'b0;
    cycles(6);
    if (n > DMIN) begin
      model_clear_regs();
      mq.delete();
      exp_dresets++;
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned exp_bc;
    exp_bc = (mq.size() > FRAME_BITS + 1) ? FRAME_BITS + 1 : 32'(mq.size());
    check_eq({tag, ".bit_count"}, 32'(bus.bit_count), exp_bc);
    check_eq({tag, ".strobes"}, 32'(seen_strobes), 32'(exp_strobes));
    check_eq({tag, ".errors"}, 32'(seen_errors), 32'(exp_errors));
    check_eq({tag, ".dresets"}, 32'(seen_dresets), 32'(exp_dresets));
    check_eq({tag, ".write_addr"}, 32'(bus.write_addr), 32'(exp_waddr));
    check_eq({tag, ".write_data"}, 32'(bus.write_data), 32'(exp_wdata));
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < (1 << ADDR_WIDTH); a++) begin
      bus.read_addr = ADDR_WIDTH'(a);
      cycles(1);
      check_eq($sformatf("%s.reg%0d", tag, a), 32'(bus.read_data),
               (a < NREGS) ? 32'(mregs[a]) : 32'd0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".bit_count"}, 32'(bus.bit_count), 32'd0);
    check_eq({tag, ".read_data"}, 32'(bus.read_data), 32'd0);
    check_eq({tag, ".write_addr"}, 32'(bus.write_addr), 32'd0);
    check_eq({tag, ".write_data"}, 32'(bus.write_data), 32'd0);
    check_eq({tag, ".pulses"}, {29'd0, bus.write_strobe, bus.frame_error, bus.dreset_detected}, 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    model_clear_regs();
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  initial begin
    int lat;
    bit found;
    logic [FRAME_BITS-1:0] w;
    int unsigned nbits, k, op;

    bus.sin = 1'b0;
    bus.sclk = 1'b0;
    bus.pclk = 1'b0;
    bus.read_addr = '0;
    model_reset();
    cycles(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    cycles(3);
    check_state("post_reset");

    // Directed: full frame to reg 2, latency and readback timing.
    bus.read_addr = ADDR_WIDTH'(2);
    send_bits(0, FRAME_BITS, {4'h2, 12'hb44});
    check_eq("t1.bit_count_full", 32'(bus.bit_count), 32'd16);
    bus.pclk = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      cycles(1);
      if (bus.write_strobe) begin
        found = 1'b1;
        lat = i;
        check_eq("t1.read_old", 32'(bus.read_data), 32'd0);
      end
    end
    check_eq("t1.latency", 32'(lat), SYNC + 1);
    cycles(1);
    check_eq("t1.read_new", 32'(bus.read_data), 32'h0b44);
    bus.pclk = 1'b0;
    cycles(4);
    model_latch();
    check_state("t1");

    // Short frame, then a good frame.
    send_bits(0, 15, 16'h5123);
    pulse_pclk();
    check_state("t2.short");
    send_bits(0, FRAME_BITS, {4'h5, 12'h3c7});
    pulse_pclk();
    check_state("t2.good");

    // Overrun saturates the bit count.
    send_bits(0, 20, {4'h1, 12'hfff});
    check_state("t3.overrun");
    pulse_pclk();
    check_state("t3.err");
    // Out-of-range address is rejected.
    send_bits(0, FRAME_BITS, {4'hd, 12'h123});
    pulse_pclk();
    check_state("t3.addr_oor");
    check_regs("t3");

    // Load regs 0..3, then dreset.
    send_bits(0, FRAME_BITS, {4'h0, 12'h844}); pulse_pclk();
    send_bits(0, FRAME_BITS, {4'h1, 12'hb44}); pulse_pclk();
    send_bits(0, FRAME_BITS, {4'h2, 12'h844}); pulse_pclk();
    send_bits(0, FRAME_BITS, {4'h3, 12'h844}); pulse_pclk();
    check_regs("t4.loaded");
    both_high(10, 1'b0);
    check_state("t4.dreset");
    check_regs("t4.cleared");

    // Short glitch mid-frame preserves progress.
    w = {4'h7, 12'h5a3};
    send_bits(0, 7, w);
    both_high(3, 1'b1);
    check_state("t5.glitch");
    send_bits(7, FRAME_BITS, w);
    pulse_pclk();
    check_state("t5.frame");

    // Async reset mid-frame.
    bus.read_addr = ADDR_WIDTH'(7);
    send_bits(0, 9, {4'h4, 12'h0ff});
    check_state("t6.mid");
    check_eq("t6.read_before", 32'(bus.read_data), 32'h05a3);
    reset = 1'b0;
    #1;
    check_outputs_zero("t6.async");
    model_reset();
    cycles(2);
    reset = 1'b1;
    cycles(3);
    check_regs("t6.regs");

    // Async reset during dreset pending, then a frame must latch normally.
    bus.sclk = 1'b1;
    bus.pclk = 1'b1;
    cycles(4);
    reset = 1'b0;
    #1;
    check_outputs_zero("t6.pend");
    model_reset();
    bus.sclk = 1'b0;
    bus.pclk = 1'b0;
    cycles(4);
    reset = 1'b1;
    cycles(3);
    send_bits(0, FRAME_BITS, {4'h9, 12'h6e1});
    pulse_pclk();
    check_state("t6.after");

    // Randomized sequence.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : FRAME_BITS;
        w = FRAME_BITS'($urandom);
        if (op == 5) begin
          k = $urandom_range(0, nbits);
          send_bits(0, k, w);
          both_high($urandom_range(1, 6), 1'($urandom));
          check_state($sformatf("rnd%0d.glitch", it));
          send_bits(k, nbits, w);
        end else begin
          send_bits(0, nbits, w);
        end
        pulse_pclk();
      end else if (op == 6) begin
        both_high($urandom_range(10, 14), 1'($urandom));
      end else if (op == 7) begin
        both_high($urandom_range(1, 6), 1'($urandom));
      end else begin
        check_regs($sformatf("rnd%0d", it));
      end
      check_state($sformatf("rnd%0d", it));
    end
    check_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
